uart_ascii_sender: RTL and testbench

Transmit-side message generator for the UART path. On a send request it converts a 14-bit binary value into four ASCII decimal digits and an optional CR/LF terminator. It then hands the bytes one at a time to the UART transmitter through a start/busy/done handshake. It sits between the application logic (counters, stopwatch, sensor values) and `uart_tx`, replacing the debounced button as the transmitter's start source.

---
 rtl/uart_ascii_sender_pkg.sv | 27 ++
 rtl/uart_ascii_sender_if.sv | 36 +++
 rtl/uart_ascii_sender_bin2bcd_seq.sv | 56 +++++
 rtl/uart_ascii_sender.sv | 127 ++++++++++++
 tb/tb_uart_ascii_sender.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ascii_sender_pkg.sv
// Shared definitions for the UART ASCII message path: FSM encoding, ASCII
// constants and the input saturation helper. Also used by the RX command decoder.
package uart_ascii_sender_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StStart,
        StWait,
        StDone
    } state_e;

    localparam logic [7:0]  ASCII_ZERO = 8'h30;
    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;

    // Clamp to the largest value that fits in four decimal digits.
    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > MAX_VALUE) ? MAX_VALUE : v;
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/uart_ascii_sender_if.sv
// Handshake bundle between the application, the ASCII sender and uart_tx.
// The slave modport is the sender's view; master is the surrounding logic.
interface uart_ascii_sender_if;

    logic        i_send;
    logic [13:0] i_value;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_send,
        output i_value,
        output i_tx_busy,
        output i_tx_done,
        input  o_tx_start,
        input  o_tx_data,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_send,
        input  i_value,
        input  i_tx_busy,
        input  i_tx_done,
        output o_tx_start,
        output o_tx_data,
        output o_busy,
        output o_done
    );

endinterface

// File: rtl/uart_ascii_sender_bin2bcd_seq.sv
// Sequential double-dabble: 14-bit binary to 4-digit packed BCD, one shift per
// cycle. start loads the operand and clears the result; done is high during the
// cycle whose closing edge performs the 14th shift, so bcd is final right after.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        done
);

    localparam logic [3:0] LastShift = 4'd13;

    logic        active_q;
    logic [3:0]  cnt_q;
    logic [13:0] shreg_q;
    logic [15:0] bcd_q;
    logic [15:0] adj;

    // Add 3 to every nibble that is 5 or more before the shift.
    always_comb begin
        adj = bcd_q;
        for (int n = 0; n < 4; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift MSB-first for exactly 14 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= 4'd0;
            shreg_q  <= 14'd0;
            bcd_q    <= 16'd0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= 4'd0;
            shreg_q  <= bin;
            bcd_q    <= 16'd0;
        end else if (active_q) begin
            bcd_q    <= (adj << 1) | {15'd0, shreg_q[13]};
            shreg_q  <= shreg_q << 1;
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == LastShift) begin
                active_q <= 1'b0;
            end
        end
    end

    assign bcd  = bcd_q;
    assign done = active_q && (cnt_q == LastShift);

endmodule

// File: rtl/uart_ascii_sender.sv
// Converts a 14-bit value to four ASCII decimal digits (plus optional CR/LF)
// and feeds them one byte at a time into uart_tx via start/busy/done.
module uart_ascii_sender
    import uart_ascii_sender_pkg::*;
#(
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_ascii_sender_if.slave   bus
);

    localparam logic [2:0] LastIdx = SEND_CRLF ? 3'd5 : 3'd3;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [13:0] value_sat;
    logic        conv_start;
    logic        conv_done;
    logic [15:0] bcd;
    logic [7:0]  byte_sel;
    logic        load_data;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        done_q;

    assign value_sat = saturate(bus.i_value);

    // The converter's shift register is the latch for the accepted value.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (value_sat),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Select the byte for the current index: digits MSD first, then CR, LF.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0:    byte_sel = digit_ascii(bcd[15:12]);
            3'd1:    byte_sel = digit_ascii(bcd[11:8]);
            3'd2:    byte_sel = digit_ascii(bcd[7:4]);
            3'd3:    byte_sel = digit_ascii(bcd[3:0]);
            3'd4:    byte_sel = ASCII_CR;
            3'd5:    byte_sel = ASCII_LF;
            default: byte_sel = 8'h00;
        endcase
    end

    // Next-state logic; requests and done pulses outside their states are dropped.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        conv_start = 1'b0;
        load_data  = 1'b0;
        tx_start_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.i_send) begin
                    conv_start = 1'b1;
                    idx_d      = 3'd0;
                    state_d    = StConv;
                end
            end
            StConv: begin
                if (conv_done) begin
                    state_d = StConv == StConv ? StStart : StConv;
                end
            end
            StStart: begin
                // Data is reloaded every START cycle so it is valid with the pulse.
                load_data = 1'b1;
                if (!bus.i_tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (bus.i_tx_done) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StStart;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset aborts any message immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_q == StDone);
            if (load_data) begin
                tx_data_q <= byte_sel;
            end
        end
    end

    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_uart_ascii_sender.sv
// Bench for uart_ascii_sender: one instance with CR/LF, one without, each
// driven by an ideal transmitter (busy 100 cycles, then a done pulse).
module tb_uart_ascii_sender;

    localparam int TX_LEN = 100;

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    uart_ascii_sender_if b6 ();
    uart_ascii_sender_if b4 ();

    uart_ascii_sender #(.SEND_CRLF(1'b1)) dut6 (.clk(clk), .rst(rst), .bus(b6));
    uart_ascii_sender #(.SEND_CRLF(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    // Transmitter model state and test knobs.
    logic ext_busy   = 1'b0;
    logic stray_done = 1'b0;
    logic m_busy [2];
    logic m_done [2];
    int   tx_cnt [2];

    assign b6.i_tx_busy = m_busy[0] | ext_busy;
    assign b6.i_tx_done = m_done[0] | stray_done;
    assign b4.i_tx_busy = m_busy[1];
    assign b4.i_tx_done = m_done[1];

    logic       start_w [2];
    logic       done_w  [2];
    logic       busy_w  [2];
    logic       donein_w[2];
    logic [7:0] data_w  [2];

    assign start_w[0]  = b6.o_tx_start;
    assign start_w[1]  = b4.o_tx_start;
    assign done_w[0]   = b6.o_done;
    assign done_w[1]   = b4.o_done;
    assign busy_w[0]   = b6.o_busy;
    assign busy_w[1]   = b4.o_busy;
    assign donein_w[0] = b6.i_tx_done;
    assign donein_w[1] = b4.i_tx_done;
    assign data_w[0]   = b6.o_tx_data;
    assign data_w[1]   = b4.o_tx_data;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected message byte i for value v, from decimal arithmetic.
    function automatic logic [7:0] msg_byte(input int v, input int i);
        int s;
        s = (v > 9999) ? 9999 : v;
        case (i)
            0:       return 8'(48 + s / 1000);
            1:       return 8'(48 + (s / 100) % 10);
            2:       return 8'(48 + (s / 10) % 10);
            3:       return 8'(48 + s % 10);
            4:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    function automatic void exp_push(input int u, input logic [7:0] b);
        if (u == 0) exp0.push_back(b); else exp1.push_back(b);
    endfunction
    function automatic int exp_size(input int u);
        return (u == 0) ? exp0.size() : exp1.size();
    endfunction
    function automatic logic [7:0] exp_pop(input int u);
        return (u == 0) ? exp0.pop_front() : exp1.pop_front();
    endfunction
    function automatic void cap_push(input int u, input logic [7:0] b);
        if (u == 0) cap0.push_back(b); else cap1.push_back(b);
    endfunction
    function automatic int cap_size(input int u);
        return (u == 0) ? cap0.size() : cap1.size();
    endfunction
    function automatic logic [7:0] cap_at(input int u, input int i);
        return (u == 0) ? cap0[i] : cap1[i];
    endfunction
    function automatic void cap_clear(input int u);
        if (u == 0) cap0.delete(); else cap1.delete();
    endfunction

    // Ideal transmitter: busy for TX_LEN cycles after a start, then a done pulse.
    initial begin
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 1'b0;
            m_done[u] = 1'b0;
            tx_cnt[u] = 0;
        end
        forever begin
            @(posedge clk);
            #2;
            for (int u = 0; u < 2; u++) begin
                m_done[u] = 1'b0;
                if (tx_cnt[u] > 0) begin
                    tx_cnt[u]--;
                    if (tx_cnt[u] == 0) begin
                        m_busy[u] = 1'b0;
                        m_done[u] = 1'b1;
                    end
                end else if (start_w[u]) begin
                    m_busy[u] = 1'b1;
                    tx_cnt[u] = TX_LEN;
                end
            end
        end
    end

    // Compare process: every start byte against the expected queue, data held
    // until done, and the 2-cycle done->start / done->o_done spacing.
    bit         in_flight[2];
    bit         gap_valid[2];
    logic [7:0] flight[2];
    int         last_done[2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            in_flight[u] = 1'b0;
            gap_valid[u] = 1'b0;
            flight[u]    = 8'h00;
            last_done[u] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int u = 0; u < 2; u++) begin
                if (rst) begin
                    in_flight[u] = 1'b0;
                    gap_valid[u] = 1'b0;
                end else begin
                    if (in_flight[u]) begin
                        check("data_stable", data_w[u], flight[u]);
                        if (donein_w[u]) begin
                            in_flight[u] = 1'b0;
                            gap_valid[u] = 1'b1;
                            last_done[u] = cyc;
                        end
                    end
                    if (start_w[u]) begin
                        cap_push(u, data_w[u]);
                        if (exp_size(u) == 0) check("extra_start", 1, 0);
                        else check("tx_byte", data_w[u], exp_pop(u));
                        if (gap_valid[u]) check("done_to_start", cyc - last_done[u], 2);
                        gap_valid[u] = 1'b0;
                        in_flight[u] = 1'b1;
                        flight[u]    = data_w[u];
                    end
                    if (done_w[u]) begin
                        if (gap_valid[u]) check("done_to_o_done", cyc - last_done[u], 2);
                        else check("o_done_orphan", 1, 0);
                        gap_valid[u] = 1'b0;
                    end
                end
            end
        end
    end

    // Accept a send, then report cycles from the accept edge to the first start.
    task automatic send_msg(input int u, input int v, output int lat);
        for (int i = 0; i < ((u == 0) ? 6 : 4); i++) exp_push(u, msg_byte(v, i));
        if (u == 0) begin b6.i_send = 1'b1; b6.i_value = 14'(v); end
        else        begin b4.i_send = 1'b1; b4.i_value = 14'(v); end
        @(negedge clk);
        if (u == 0) b6.i_send = 1'b0; else b4.i_send = 1'b0;
        check("busy_rise", busy_w[u], 1);
        lat = 0;
        while (!start_w[u] && lat < 500) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(input int u);
        int n = 0;
        while (!done_w[u] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("done_seen", int'(n < 3000), 1);
        check("busy_fall", busy_w[u], 0);
    endtask

    task automatic check_cap(input int u, input string name, input logic [7:0] lit[6],
                             input int n);
        check({name, "_count"}, cap_size(u), n);
        for (int i = 0; i < n && i < cap_size(u); i++) check(name, cap_at(u, i), lit[i]);
        check({name, "_exp_left"}, exp_size(u), 0);
        cap_clear(u);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         seen;
        logic [7:0] lit[6];

        rst        = 1'b1;
        b6.i_send  = 1'b0;
        b6.i_value = 14'd0;
        b4.i_send  = 1'b0;
        b4.i_value = 14'd0;
        repeat (3) @(negedge clk);
        check("rst_start6", b6.o_tx_start, 0);
        check("rst_data6",  b6.o_tx_data,  0);
        check("rst_busy6",  b6.o_busy,     0);
        check("rst_done6",  b6.o_done,     0);
        check("rst_start4", b4.o_tx_start, 0);
        check("rst_busy4",  b4.o_busy,     0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic value, then back-to-back sends of 0 and a saturating value.
        send_msg(0, 1234, lat);
        check("latency_1234", lat, 15);
        wait_done(0);
        lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check_cap(0, "msg_1234", lit, 6);

        send_msg(0, 0, lat);
        check("latency_0", lat, 15);
        wait_done(0);
        lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        check_cap(0, "msg_0", lit, 6);

        send_msg(0, 16383, lat);
        wait_done(0);
        lit = '{8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
        check_cap(0, "msg_16383", lit, 6);

        // Busy gating, ignored send/done pulses and a changing i_value.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) exp_push(0, msg_byte(5678, i));
        ext_busy   = 1'b1;
        b6.i_value = 14'd5678;
        b6.i_send  = 1'b1;
        @(negedge clk);
        b6.i_send  = 1'b0;
        b6.i_value = 14'd1111;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (start_w[0]) seen++;
            b6.i_send  = (i == 20);
            stray_done = (i == 24);
        end
        check("gated_no_start", seen, 0);
        ext_busy = 1'b0;
        @(negedge clk);
        check("gated_start", start_w[0], 1);
        repeat (150) @(negedge clk);
        b6.i_send  = 1'b1;
        b6.i_value = 14'd42;
        @(negedge clk);
        b6.i_send  = 1'b0;
        wait_done(0);
        lit = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
        check_cap(0, "msg_5678", lit, 6);
        repeat (30) @(negedge clk);
        #1;
        check("no_queued_busy", busy_w[0], 0);
        check("no_queued_start", cap_size(0), 0);

        // Reset during the third byte's WAIT, then a fresh message.
        @(negedge clk);
        send_msg(0, 2468, lat);
        seen = 0;
        while (cap_size(0) < 3 && seen < 1000) begin
            @(negedge clk);
            #1;
            seen++;
        end
        check("abort_reached_byte3", cap_size(0), 3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_start", b6.o_tx_start, 0);
        check("abort_data",  b6.o_tx_data,  0);
        check("abort_busy",  b6.o_busy,     0);
        check("abort_done",  b6.o_done,     0);
        exp0.delete();
        cap0.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        check("abort_no_start", cap_size(0), 0);
        check("abort_idle", busy_w[0], 0);
        @(negedge clk);
        send_msg(0, 5, lat);
        check("latency_5", lat, 15);
        wait_done(0);
        lit = '{8'h30, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A};
        check_cap(0, "msg_5", lit, 6);

        // No terminator.
        @(negedge clk);
        send_msg(1, 907, lat);
        check("latency_907", lat, 15);
        wait_done(1);
        lit = '{8'h30, 8'h39, 8'h30, 8'h37, 8'h00, 8'h00};
        check_cap(1, "msg_907", lit, 4);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
